wbm_arbiter: RTL and testbench

WBM_ARBITER -- requirements
Module: wbm_arbiter

---
 rtl/wbm_arbiter.sv | 143 ++++++++++++++
 tb/tb_wbm_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wbm_arbiter.sv
// ---------------------------------------------------------------------------
// wbm_arbiter -- five-channel round-robin Wishbone master arbiter.
//
// Picks one of five requesting channels and holds the grant until the owner
// drops its request or the shared bus stalls for TIMEOUT granted cycles
// without a termination. Every grant is followed by one RELEASE cycle with
// gnt==0, so the mixer select never switches directly between channels.
// A channel released by timeout is masked until it drops its request.
//
// Optional feature: define ARB_PRIO4_EN to make channel 4 (management) win
// every arbitration it is eligible for. The pointer does not move when
// channel 4 wins, so channels 0-3 keep their round-robin order.
//
// Ports:
//   wb_clk_i     clock, all state on the rising edge
//   wb_rst_i     synchronous active-high reset
//   req[4:0]     per-channel request (cyc of each slave-side port)
//   wbm_ack_i    shared-bus terminations; only restart the timeout counter
//   wbm_err_i
//   wbm_rty_i
//   gnt[4:0]     registered one-hot grant (or zero)
//   gnt_idx[2:0] registered binary index of the grant, 0 when idle
//   busy         registered, high whenever gnt != 0
//   arb_timeout  one-cycle pulse in the RELEASE cycle of a forced release
// ---------------------------------------------------------------------------
module wbm_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [4:0] req,
    input  logic       wbm_ack_i,
    input  logic       wbm_err_i,
    input  logic       wbm_rty_i,
    output logic [4:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       busy,
    output logic       arb_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [4:0] mask;
    logic [2:0] ptr;

    logic [4:0] eligible;
    logic       win_vld;
    logic [2:0] win;
    logic       ptr_upd;
    logic       term;
    logic       owner_req;
    logic       expire;
    logic [4:0] mask_nxt;

    // First eligible channel after p, wrapping mod 5. Walking the offsets
    // from far to near lets the nearest hit overwrite the others.
    function automatic logic [2:0] rr_pick(input logic [4:0] elig,
                                           input logic [2:0] p);
        logic [2:0] w;
        logic [2:0] c;
        w = 3'd0;
        for (int k = 5; k >= 1; k--) begin
            c = 3'((int'(p) + k) % 5);
            if (elig[c]) w = c;
        end
        return w;
    endfunction

    always_comb begin
        eligible  = req & ~mask;
        win_vld   = |eligible;
`ifdef ARB_PRIO4_EN
        if (eligible[4]) begin
            win     = 3'd4;
            ptr_upd = 1'b0;
        end else begin
            win     = rr_pick(eligible, ptr);
            ptr_upd = 1'b1;
        end
`else
        win       = rr_pick(eligible, ptr);
        ptr_upd   = 1'b1;
`endif
        term      = wbm_ack_i | wbm_err_i | wbm_rty_i;
        owner_req = req[gnt_idx];
        // A termination in the last allowed cycle rescues the owner.
        expire    = (state == GRANT) && (cnt == 8'(TIMEOUT - 1)) && !term;
        // Set beats clear: an owner dropping req as it times out is still
        // masked for the RELEASE cycle, then cleared there since req is low.
        mask_nxt  = (mask & req) | (expire ? (5'b00001 << gnt_idx) : 5'b00000);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            gnt         <= 5'b00000;
            gnt_idx     <= 3'd0;
            busy        <= 1'b0;
            arb_timeout <= 1'b0;
            cnt         <= 8'd0;
            mask        <= 5'b00000;
            ptr         <= 3'd4;
        end else begin
            mask        <= mask_nxt;
            arb_timeout <= 1'b0;
            case (state)
                GRANT: begin
                    if (!owner_req || expire) begin
                        state       <= RELEASE;
                        gnt         <= 5'b00000;
                        gnt_idx     <= 3'd0;
                        busy        <= 1'b0;
                        arb_timeout <= expire;
                    end else begin
                        cnt <= term ? 8'd0 : cnt + 8'd1;
                    end
                end
                default: begin // IDLE and RELEASE arbitrate identically
                    if (win_vld) begin
                        state   <= GRANT;
                        gnt     <= 5'b00001 << win;
                        gnt_idx <= win;
                        busy    <= 1'b1;
                        cnt     <= 8'd0;
                        if (ptr_upd) ptr <= win;
                    end else begin
                        state   <= IDLE;
                        gnt     <= 5'b00000;
                        gnt_idx <= 3'd0;
                        busy    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wbm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wbm_arbiter -- directed scenarios followed by randomized traffic, every
// cycle compared against a channel-level reference model (owner number,
// timeout count, per-channel mask flags, last-granted pointer).
// ---------------------------------------------------------------------------
module tb_wbm_arbiter;
    localparam int TMO = 4;
`ifdef ARB_PRIO4_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic       ack, err, rty;
    logic [4:0] gnt;
    logic [2:0] gnt_idx;
    logic       busy;
    logic       arb_timeout;

    wbm_arbiter #(.TIMEOUT(TMO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .req        (req),
        .wbm_ack_i  (ack),
        .wbm_err_i  (err),
        .wbm_rty_i  (rty),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .busy       (busy),
        .arb_timeout(arb_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: who owns the bus (-1 = nobody), how long it has gone
    // without a termination, which channels are locked out, who won last.
    int       m_owner;
    int       m_cnt;
    int       m_ptr;
    bit       m_to;
    bit [4:0] m_mask;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r_st, input logic [4:0] r, input bit term);
        int  win;
        bit  expire;
        if (r_st) begin
            m_owner = -1; m_cnt = 0; m_mask = '0; m_ptr = 4; m_to = 0;
        end else if (m_owner < 0) begin
            win  = -1;
            m_to = 0;
            if (PRIO && r[4] && !m_mask[4]) win = 4;
            for (int k = 1; k <= 5; k++) begin
                int c;
                c = (m_ptr + k) % 5;
                if (win < 0 && r[c] && !m_mask[c]) win = c;
            end
            m_mask = m_mask & r;
            if (win >= 0) begin
                m_owner = win;
                m_cnt   = 0;
                if (!(PRIO && win == 4)) m_ptr = win;
            end
        end else begin
            expire = (m_cnt == TMO - 1) && !term;
            m_mask = m_mask & r;
            if (!r[m_owner] || expire) begin
                if (expire) m_mask[m_owner] = 1'b1;
                m_to    = expire;
                m_owner = -1;
            end else begin
                m_to  = 0;
                m_cnt = term ? 0 : m_cnt + 1;
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, check after the edge.
    task automatic cycle(input logic [4:0] r, input logic a, input logic e,
                         input logic y, input logic rs);
        logic [4:0] eg;
        req = r; ack = a; err = e; rty = y; rst = rs;
        model_step(rs, r, a | e | y);
        @(posedge clk);
        #1;
        eg = (m_owner < 0) ? 5'd0 : (5'd1 << m_owner);
        chk("gnt",         8'(gnt),         8'(eg));
        chk("gnt_idx",     8'(gnt_idx),     8'((m_owner < 0) ? 0 : m_owner));
        chk("busy",        8'(busy),        8'(m_owner >= 0));
        chk("arb_timeout", 8'(arb_timeout), 8'(m_to));
    endtask

    task automatic do_reset();
        cycle(5'b00000, 0, 0, 0, 1);
        cycle(5'b00000, 0, 0, 0, 1);
    endtask

    initial begin
        logic [4:0] r;
        logic [4:0] bit_ch;
        int         ch;
        rst = 1'b1; req = '0; ack = 0; err = 0; rty = 0;
        m_owner = -1; m_cnt = 0; m_mask = '0; m_ptr = 4; m_to = 0;

        // Reset state
        do_reset();
        chk("rst_gnt",  8'(gnt), 8'h00);
        chk("rst_idx",  8'(gnt_idx), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_to",   8'(arb_timeout), 8'h00);

        // Two requesters, one-cycle latency, one zero cycle between owners
        cycle(5'b00101, 0, 0, 0, 0);
        chk("basic_first", 8'(gnt), 8'h01);
        cycle(5'b00101, 0, 0, 0, 0);
        cycle(5'b00101, 0, 0, 0, 0);
        cycle(5'b00100, 0, 0, 0, 0);
        chk("basic_release", 8'(gnt), 8'h00);
        cycle(5'b00100, 0, 0, 0, 0);
        chk("basic_second", 8'(gnt), 8'h04);

        // All channels requesting, each owner holds three cycles
        do_reset();
        for (int k = 0; k < 6; k++) begin
            ch = k % 5;
            bit_ch = 5'd1 << ch;
            for (int h = 0; h < 3; h++) begin
                cycle(5'b11111, 0, 0, 0, 0);
                chk("rr_hold", 8'(gnt), 8'(bit_ch));
            end
            cycle(5'b11111 & ~bit_ch, 0, 0, 0, 0);
            chk("rr_gap", 8'(gnt), 8'h00);
        end

        // Timeout with no terminations, then lock-out until req drops
        do_reset();
        for (int k = 0; k < TMO; k++) begin
            cycle(5'b00010, 0, 0, 0, 0);
            chk("to_hold", 8'(gnt), 8'h02);
        end
        cycle(5'b00010, 0, 0, 0, 0);
        chk("to_drop", 8'(gnt), 8'h00);
        chk("to_pulse", 8'(arb_timeout), 8'h01);
        for (int k = 0; k < 3; k++) begin
            cycle(5'b00010, 0, 0, 0, 0);
            chk("to_masked", 8'(gnt), 8'h00);
            chk("to_single", 8'(arb_timeout), 8'h00);
        end
        cycle(5'b00000, 0, 0, 0, 0);
        cycle(5'b00010, 0, 0, 0, 0);
        chk("to_regrant", 8'(gnt), 8'h02);

        // Ack every third cycle keeps the grant alive
        do_reset();
        cycle(5'b00010, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(5'b00010, (i % 3) == 2, 0, 0, 0);
            chk("ack3_gnt", 8'(gnt), 8'h02);
            chk("ack3_to",  8'(arb_timeout), 8'h00);
        end

        // Termination exactly on the last allowed cycle (err and rty too)
        do_reset();
        cycle(5'b00010, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cycle(5'b00010, 0, (i == 3), (i == 7 || i == 11), 0);
            chk("edge_gnt", 8'(gnt), 8'h02);
        end
        // Owner drops req in the very cycle the timeout fires
        cycle(5'b00010, 0, 0, 0, 0);
        cycle(5'b00010, 0, 0, 0, 0);
        cycle(5'b00010, 0, 0, 0, 0);
        cycle(5'b00000, 0, 0, 0, 0);
        chk("drop_to_pulse", 8'(arb_timeout), 8'h01);
        cycle(5'b00000, 0, 0, 0, 0);
        cycle(5'b00010, 0, 0, 0, 0);
        chk("drop_to_regrant", 8'(gnt), 8'h02);

        // Management channel priority (or plain round-robin)
        do_reset();
        cycle(5'b00001, 0, 0, 0, 0);
        cycle(5'b10110, 0, 0, 0, 0);
        cycle(5'b10110, 0, 0, 0, 0);
`ifdef ARB_PRIO4_EN
        chk("prio_first", 8'(gnt), 8'h10);
        cycle(5'b00110, 0, 0, 0, 0);
        cycle(5'b00110, 0, 0, 0, 0);
        chk("prio_next", 8'(gnt), 8'h02);
`else
        chk("prio_first", 8'(gnt), 8'h02);
        cycle(5'b10100, 0, 0, 0, 0);
        cycle(5'b10100, 0, 0, 0, 0);
        chk("prio_next", 8'(gnt), 8'h04);
`endif

        // Reset mid-grant, then arbitration resumes from channel 0
        do_reset();
        cycle(5'b01000, 0, 0, 0, 0);
        chk("mid_rst_pre", 8'(gnt), 8'h08);
        cycle(5'b01000, 0, 0, 0, 0);
        cycle(5'b01000, 0, 0, 0, 1);
        chk("mid_rst_gnt", 8'(gnt), 8'h00);
        chk("mid_rst_to",  8'(arb_timeout), 8'h00);
        cycle(5'b01001, 0, 0, 0, 0);
        chk("mid_rst_resume", 8'(gnt), 8'h01);

        // Randomized traffic against the model
        do_reset();
        r = 5'b00000;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            cycle(r, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
